// File: rtl/store_drain_unit.sv
// store_drain_unit: drains committed stores from the store queue into the
// D-cache one at a time (IDLE -> REQ -> WAIT), releasing each store-queue
// entry when the cache acknowledges the write.
//
// Handshake: the D-cache request is a strict valid/ready transfer. Once
// dc_req_valid rises, it stays high and addr/data stay constant until the
// cycle in which dc_req_valid && dc_req_ready. After that the request is
// considered in flight until a dc_ack pulse. An ack seen in any other state
// is ignored.
module store_drain_unit #(
  parameter int SQ_SIZE  = 8,
  parameter int COMMIT_W = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(COMMIT_W+1)-1:0]   commit_store_cnt,
  output logic [$clog2(SQ_SIZE)-1:0]      sq_read_pointer,
  input  logic [ADDR_W-1:0]               sq_mem_addr,
  input  logic [DATA_W-1:0]               sq_sw_data,
  output logic                            dc_req_valid,
  output logic [ADDR_W-1:0]               dc_req_addr,
  output logic [DATA_W-1:0]               dc_req_data,
  input  logic                            dc_req_ready,
  input  logic                            dc_ack,
  output logic                            sq_release_valid,
  output logic [$clog2(SQ_SIZE)-1:0]      sq_release_idx,
  output logic                            drain_empty,
  output logic                            overflow_err,
  output logic [1:0]                      state_dbg,
  output logic [$clog2(SQ_SIZE):0]        pending_dbg
);

  localparam int PTR_W = $clog2(SQ_SIZE);
  localparam int PW    = $clog2(SQ_SIZE) + 1;
  localparam int CW    = $clog2(COMMIT_W + 1);
  localparam int SW    = PW + CW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pending_q, pending_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;

  logic              release_fire;
  logic [SW-1:0]     sum_add;
  logic [SW-1:0]     sum_net;

  // Pending-count update, overflow detection and FSM next state.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    release_fire = (state_q == WAIT) && dc_ack && !rst;

    // Commits and the release land in the same cycle; the release never
    // drives the count below zero.
    sum_add = SW'(pending_q) + SW'(commit_store_cnt);
    sum_net = sum_add;
    if (release_fire && (sum_add != '0)) begin
      sum_net = sum_add - SW'(1);
    end

    if (sum_net > SW'(SQ_SIZE)) begin
      pending_d  = PW'(SQ_SIZE);
      overflow_d = 1'b1;
    end else begin
      pending_d  = sum_net[PW-1:0];
    end

    case (state_q)
      IDLE: begin
        // pending_d includes this cycle's commits, so they issue next cycle.
        if (pending_d != '0) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (dc_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dc_ack) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          state_d  = (pending_d != '0) ? REQ : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pending count, read pointer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Request and release outputs are suppressed while reset is held so an
  // in-flight request is abandoned without a release pulse.
  always_comb begin
    dc_req_valid     = (state_q == REQ) && !rst;
    dc_req_addr      = sq_mem_addr;
    dc_req_data      = sq_sw_data;
    sq_release_valid = release_fire;
    sq_release_idx   = rd_ptr_q;
    sq_read_pointer  = rd_ptr_q;
    drain_empty      = rst || ((state_q == IDLE) && (pending_q == '0));
    overflow_err     = overflow_q;
    state_dbg        = state_q;
    pending_dbg      = pending_q;
  end

endmodule

// File: tb/tb_store_drain_unit.sv
// tb_store_drain_unit: directed vector table plus hand-written multi-cycle
// sequences for the store drain unit.
module tb_store_drain_unit;

  localparam int SQ = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [2:0]    commit_store_cnt;
  logic [2:0]    sq_read_pointer;
  logic [AW-1:0] sq_mem_addr;
  logic [DW-1:0] sq_sw_data;
  logic          dc_req_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_data;
  logic          dc_req_ready;
  logic          dc_ack;
  logic          sq_release_valid;
  logic [2:0]    sq_release_idx;
  logic          drain_empty;
  logic          overflow_err;
  logic [1:0]    state_dbg;
  logic [3:0]    pending_dbg;

  logic [AW-1:0] sq_addr [SQ];
  logic [DW-1:0] sq_data [SQ];

  int checks;
  int failures;

  // Store-queue contents seen at the read pointer.
  assign sq_mem_addr = sq_addr[sq_read_pointer];
  assign sq_sw_data  = sq_data[sq_read_pointer];

  store_drain_unit #(
    .SQ_SIZE(SQ), .COMMIT_W(4), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .commit_store_cnt(commit_store_cnt),
    .sq_read_pointer(sq_read_pointer),
    .sq_mem_addr(sq_mem_addr),
    .sq_sw_data(sq_sw_data),
    .dc_req_valid(dc_req_valid),
    .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data),
    .dc_req_ready(dc_req_ready),
    .dc_ack(dc_ack),
    .sq_release_valid(sq_release_valid),
    .sq_release_idx(sq_release_idx),
    .drain_empty(drain_empty),
    .overflow_err(overflow_err),
    .state_dbg(state_dbg),
    .pending_dbg(pending_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] cnt;
    logic       rdy;
    logic       ack;
    logic       valid;
    logic       rel;
    logic [2:0] ptr;
    logic       empty;
    logic       err;
    logic [1:0] st;
    logic [3:0] pend;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  logic [2:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int c, input int rd, input int a,
                              input int v, input int rl, input int p, input int e,
                              input int er, input int s, input int pd);
    vec_t x;
    x.rst = 1'(r);   x.cnt = 3'(c);  x.rdy = 1'(rd); x.ack = 1'(a);
    x.valid = 1'(v); x.rel = 1'(rl); x.ptr = 3'(p);  x.empty = 1'(e);
    x.err = 1'(er);  x.st = 2'(s);   x.pend = 4'(pd);
    return x;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; commit_store_cnt = '0; dc_req_ready = 1'b0; dc_ack = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Serves requests with ready=1 and an ack the cycle after each acceptance;
  // release indices are checked against exp_q. Returns cycles used.
  task automatic run_drain(input int n, input int budget, input string tag, output int used);
    int   seen;
    logic ack_next;
    seen = 0; used = 0; ack_next = 1'b0;
    dc_req_ready = 1'b1;
    while (seen < n && used < budget) begin
      dc_ack = ack_next;
      ack_next = 1'b0;
      @(negedge clk);
      used++;
      chk({tag, "_rel_vs_ack"}, 32'(sq_release_valid), 32'(dc_ack));
      if (dc_req_valid) begin
        if (exp_q.size() > 0) begin
          chk({tag, "_addr"}, dc_req_addr, sq_addr[exp_q[0]]);
          chk({tag, "_data"}, dc_req_data, sq_data[exp_q[0]]);
        end
        ack_next = 1'b1;
      end
      if (sq_release_valid) begin
        if (exp_q.size() > 0) begin
          chk({tag, "_rel_idx"}, 32'(sq_release_idx), 32'(exp_q.pop_front()));
        end else begin
          chk({tag, "_unexpected_rel"}, 32'(sq_release_valid), 32'd0);
        end
        seen++;
      end
      next_cycle();
    end
    dc_ack = 1'b0;
    chk({tag, "_release_count"}, 32'(seen), 32'(n));
  endtask

  initial begin
    int used;
    int acc;
    checks = 0;
    failures = 0;
    for (int i = 0; i < SQ; i++) begin
      sq_addr[i] = 32'h1000_0000 + 32'(i) * 32'h40;
      sq_data[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0111);
    end

    // Rows: rst cnt rdy ack | valid rel ptr empty err state pending
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1);
    vecs[4]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 2, 1);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1);
    vecs[10] = mk(0, 2, 1, 1, 0, 1, 1, 0, 0, 2, 1);
    vecs[11] = mk(0, 0, 0, 1, 1, 0, 2, 0, 0, 1, 2);
    vecs[12] = mk(0, 0, 1, 0, 1, 0, 2, 0, 0, 1, 2);
    vecs[13] = mk(0, 0, 1, 1, 0, 1, 2, 0, 0, 2, 2);
    vecs[14] = mk(0, 0, 1, 0, 1, 0, 3, 0, 0, 1, 1);
    vecs[15] = mk(0, 0, 1, 1, 0, 1, 3, 0, 0, 2, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);

    do_reset();
    rst = 1'b1;

    // Table: single store, stray ack in IDLE, commit during ack cycle.
    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; commit_store_cnt = vecs[i].cnt;
      dc_req_ready = vecs[i].rdy; dc_ack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(dc_req_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_rel", i), 32'(sq_release_valid), 32'(vecs[i].rel));
      chk($sformatf("vec%0d_ptr", i), 32'(sq_read_pointer), 32'(vecs[i].ptr));
      chk($sformatf("vec%0d_empty", i), 32'(drain_empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_err", i), 32'(overflow_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
      chk($sformatf("vec%0d_pend", i), 32'(pending_dbg), 32'(vecs[i].pend));
      if (vecs[i].rel) chk($sformatf("vec%0d_rel_idx", i), 32'(sq_release_idx), 32'(vecs[i].ptr));
      if (vecs[i].valid) chk($sformatf("vec%0d_addr", i), dc_req_addr, sq_addr[vecs[i].ptr]);
      next_cycle();
    end
    dc_ack = 1'b0; commit_store_cnt = '0;

    // Burst with wrap: drain six singles, then commit four at once.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(3'(k));
      commit_store_cnt = 3'd1; dc_req_ready = 1'b1;
      next_cycle();
      commit_store_cnt = 3'd0;
      run_drain(1, 20, $sformatf("single%0d", k), used);
    end
    @(negedge clk);
    chk("preset_ptr", 32'(sq_read_pointer), 32'd6);
    next_cycle();
    exp_q.push_back(3'd6); exp_q.push_back(3'd7);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    commit_store_cnt = 3'd4;
    next_cycle();
    commit_store_cnt = 3'd0;
    run_drain(4, 40, "burst", used);
    chk("burst_cycles", 32'(used), 32'd8);
    @(negedge clk);
    chk("burst_ptr_end", 32'(sq_read_pointer), 32'd2);
    chk("burst_empty_end", 32'(drain_empty), 32'd1);
    next_cycle();

    // Reset in WAIT coinciding with dc_ack.
    commit_store_cnt = 3'd1; dc_req_ready = 1'b1;
    next_cycle();
    commit_store_cnt = 3'd0;
    next_cycle();
    rst = 1'b1; dc_ack = 1'b1;
    @(negedge clk);
    chk("rstwait_state_before", 32'(state_dbg), 32'd2);
    chk("rstwait_rel", 32'(sq_release_valid), 32'd0);
    chk("rstwait_valid", 32'(dc_req_valid), 32'd0);
    chk("rstwait_empty", 32'(drain_empty), 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rel", 32'(sq_release_valid), 32'd0);
    chk("postrst_ptr", 32'(sq_read_pointer), 32'd0);
    chk("postrst_empty", 32'(drain_empty), 32'd1);
    chk("postrst_state", 32'(state_dbg), 32'd0);
    chk("postrst_valid", 32'(dc_req_valid), 32'd0);
    next_cycle();
    dc_ack = 1'b0;
    @(negedge clk);
    chk("postrst_ptr_hold", 32'(sq_read_pointer), 32'd0);
    next_cycle();

    // Back-pressure: ready low five cycles, request must hold steady.
    commit_store_cnt = 3'd1; dc_req_ready = 1'b0;
    next_cycle();
    commit_store_cnt = 3'd0;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      dc_req_ready = (j == 5);
      @(negedge clk);
      chk($sformatf("bp%0d_valid", j), 32'(dc_req_valid), 32'd1);
      chk($sformatf("bp%0d_addr", j), dc_req_addr, sq_addr[0]);
      chk($sformatf("bp%0d_data", j), dc_req_data, sq_data[0]);
      if (dc_req_valid && dc_req_ready) acc++;
      next_cycle();
    end
    dc_req_ready = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd1);
    @(negedge clk);
    chk("bp_wait_state", 32'(state_dbg), 32'd2);
    chk("bp_wait_valid", 32'(dc_req_valid), 32'd0);
    next_cycle();
    dc_ack = 1'b1;
    @(negedge clk);
    chk("bp_rel", 32'(sq_release_valid), 32'd1);
    chk("bp_rel_idx", 32'(sq_release_idx), 32'd0);
    next_cycle();
    dc_ack = 1'b0;
    @(negedge clk);
    chk("bp_ptr", 32'(sq_read_pointer), 32'd1);
    chk("bp_empty", 32'(drain_empty), 32'd1);
    next_cycle();

    // Overflow: 4 + 4 + 1 with no ack saturates at 8 and sets the sticky flag.
    do_reset();
    dc_req_ready = 1'b0;
    commit_store_cnt = 3'd4;
    next_cycle();
    commit_store_cnt = 3'd4;
    @(negedge clk);
    chk("ovf_pend4", 32'(pending_dbg), 32'd4);
    chk("ovf_err_at4", 32'(overflow_err), 32'd0);
    next_cycle();
    commit_store_cnt = 3'd1;
    @(negedge clk);
    chk("ovf_pend8", 32'(pending_dbg), 32'd8);
    chk("ovf_err_at8", 32'(overflow_err), 32'd0);
    next_cycle();
    commit_store_cnt = 3'd0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("ovf_sat%0d", j), 32'(pending_dbg), 32'd8);
      chk($sformatf("ovf_sticky%0d", j), 32'(overflow_err), 32'd1);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_drain_unit.md
STORE_DRAIN_UNIT -- requirements
Module: store_drain_unit

Interface
REQ-001 Parameter SQ_SIZE, default 8, store queue depth (power of two, at least 2).
REQ-002 Parameter COMMIT_W, default 4, maximum number of stores committed per cycle.
REQ-003 Parameter ADDR_W, default 32, memory address width.
REQ-004 Parameter DATA_W, default 32, store data width.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on posedge clk.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port commit_store_cnt, input, $clog2(COMMIT_W+1) bits: number of stores the commit stage retired this cycle, taken oldest-first.
REQ-008 Port sq_read_pointer, output, $clog2(SQ_SIZE) bits: index of the oldest committed, undrained store queue entry.
REQ-009 Port sq_mem_addr, input, ADDR_W bits: mem_addr of the store queue entry at sq_read_pointer.
REQ-010 Port sq_sw_data, input, DATA_W bits: sw_data of the store queue entry at sq_read_pointer.
REQ-011 Port dc_req_valid, output, 1 bit: D-cache write request valid.
REQ-012 Port dc_req_addr and dc_req_data, output, ADDR_W and DATA_W bits: write address and write data.
REQ-013 Port dc_req_ready, input, 1 bit: D-cache accepts the request in the cycle where dc_req_valid and dc_req_ready are both high.
REQ-014 Port dc_ack, input, 1 bit: one-cycle pulse marking completion of the accepted write (hit or miss refill done).
REQ-015 Port sq_release_valid, output, 1 bit: one-cycle pulse to free a store queue entry.
REQ-016 Port sq_release_idx, output, $clog2(SQ_SIZE) bits: index of the entry being freed.
REQ-017 Port drain_empty, output, 1 bit: high when no committed store is pending and the FSM is in IDLE.
REQ-018 Port overflow_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-019 The block SHALL hold a pending counter (width $clog2(SQ_SIZE)+1) of committed, undrained stores.
REQ-020 Each cycle pending SHALL become pending + commit_store_cnt - (sq_release_valid ? 1 : 0), with both terms applied in the same cycle.
REQ-021 If the computed pending value exceeds SQ_SIZE, pending SHALL saturate at SQ_SIZE and overflow_err SHALL set and stay set until rst.
REQ-022 The FSM SHALL have exactly three states: IDLE, REQ and WAIT.
REQ-023 IDLE transition: go to REQ next cycle when pending > 0. Stores committed in the current cycle SHALL NOT be issued until the following cycle.
REQ-024 In REQ, dc_req_valid SHALL be 1 with dc_req_addr = sq_mem_addr and dc_req_data = sq_sw_data.
REQ-025 REQ transition: stay in REQ until dc_req_ready, then go to WAIT.
REQ-026 Once raised, the request SHALL stay stable until accepted: dc_req_valid, dc_req_addr and dc_req_data SHALL NOT change while waiting for dc_req_ready.
REQ-027 In WAIT, dc_req_valid SHALL be 0.
REQ-028 WAIT transition on dc_ack:
- sq_release_valid SHALL be 1 and sq_release_idx SHALL equal sq_read_pointer, both in the same cycle.
- sq_read_pointer SHALL increment modulo SQ_SIZE on the next edge (SQ_SIZE-1 wraps to 0).
- Next state SHALL be REQ if (pending - 1 + commit_store_cnt) > 0, else IDLE.
REQ-029 A dc_ack received outside WAIT SHALL be ignored; no release and no pointer change.
REQ-030 Minimum throughput SHALL be one store per 2 cycles (REQ accepted, then ack in the next cycle).
REQ-031 sq_release_valid SHALL be 0 in every cycle except the WAIT dc_ack cycle.
REQ-032 drain_empty SHALL be combinational from the state and pending registers.

Reset
REQ-033 While rst is high at a posedge, the block SHALL reset: state = IDLE, pending = 0, sq_read_pointer = 0, overflow_err = 0.
REQ-034 During and after reset: dc_req_valid = 0, sq_release_valid = 0, drain_empty = 1.
REQ-035 A reset asserted in REQ or WAIT SHALL abandon the in-flight request with no release pulse.
REQ-036 Any dc_ack arriving after reset SHALL be ignored per REQ-029.
REQ-037 Outputs SHALL be defined in the first cycle after reset; dc_req_addr and dc_req_data are don't-care while dc_req_valid = 0.

Verification
REQ-038 Single store: commit_store_cnt=1 at cycle 0, dc_req_ready=1, dc_ack at cycle 3 -> dc_req_valid high at cycle 1 only, release pulse idx 0 at cycle 3, drain_empty=1 at cycle 4.
REQ-039 Burst with wrap: SQ_SIZE=8, pointer preset to 6 by draining 6 stores, commit 4 in one cycle -> releases idx 6, 7, 0, 1 in order, pointer ends at 2.
REQ-040 Back-pressure: dc_req_ready low 5 cycles -> addr/data stable for 6 cycles, one acceptance, then WAIT.
REQ-041 Simultaneous events: pending=1, commit_store_cnt=2 in the dc_ack cycle -> pending=2 next cycle, FSM goes to REQ.
REQ-042 Overflow: commit 4, then 4, then 1 with no ack -> pending=8, overflow_err=1 and sticky.
REQ-043 Mid-operation reset: rst in WAIT with dc_ack in the same cycle -> no release pulse, pointer=0, drain_empty=1.
